float_to_fixed: RTL and testbench

Iterative converter from IEEE-754 single precision to a 32-bit two's-complement fixed-point word with a runtime-selectable binary-point position. It is the inverse of the fixed-to-float path: a float operand is unpacked, aligned by one bit per clock, sign-applied and held until consumed. It sits behind the float datapath wherever downstream logic needs integer or Qn values, with valid/ready handshakes on both sides.

---
 rtl/float_fixed_pkg.sv | 19 +
 rtl/float_unpack.sv | 23 ++
 rtl/float_to_fixed.sv | 171 +++++++++++++++++
 tb/tb_float_to_fixed.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/float_fixed_pkg.sv
// Shared state encoding and IEEE-754 constants for the float-to-fixed converter.
package float_fixed_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int FP_BIAS   = 127;
  localparam int MANT_W    = 23;
  // Exponent at which the implicit-one mantissa is already an integer
  localparam int SH_OFFSET = FP_BIAS + MANT_W;

  localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_NEG = 32'h8000_0000;

endpackage

// File: rtl/float_unpack.sv
// Combinational split of an IEEE-754 single into fields plus zero/inf/NaN flags.
module float_unpack
  import float_fixed_pkg::*;
(
  input  logic [31:0]       operand,
  output logic              sign,
  output logic [7:0]        exponent,
  output logic [MANT_W-1:0] mantissa,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan
);

  assign sign     = operand[31];
  assign exponent = operand[30:23];
  assign mantissa = operand[MANT_W-1:0];

  // Denormals are folded into zero: they are far below any representable Qn step
  assign is_zero = (exponent == 8'h00);
  assign is_inf  = (exponent == 8'hFF) && (mantissa == '0);
  assign is_nan  = (exponent == 8'hFF) && (mantissa != '0);

endmodule

// File: rtl/float_to_fixed.sv
// Iterative IEEE-754 single to 32-bit Qn converter, one alignment bit per clock.
// Optional FLOAT_TO_FIXED_ROUND_EN: round-to-nearest (ties away) instead of truncation.
module float_to_fixed
  import float_fixed_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] targetnumber,
  input  logic [4:0]  fixpointpos,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf
);

  state_e      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  count_q, count_d;
  logic        left_q, left_d;
  logic        sign_q, sign_d;
  logic        sat_q, sat_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        out_valid_q, out_valid_d;

  logic              up_sign;
  logic [7:0]        up_exp;
  logic [MANT_W-1:0] up_mant;
  logic              up_zero, up_inf, up_nan;

  logic signed [9:0] sh;
  logic [4:0]        sh_cnt;
  logic [31:0]       mag_fin;

  float_unpack u_unpack (
    .operand  (targetnumber),
    .sign     (up_sign),
    .exponent (up_exp),
    .mantissa (up_mant),
    .is_zero  (up_zero),
    .is_inf   (up_inf),
    .is_nan   (up_nan)
  );

  // Net alignment: positive shifts left, negative shifts right
  assign sh     = $signed({2'b00, up_exp}) - $signed(10'(SH_OFFSET))
                + $signed({5'b00000, fixpointpos});
  assign sh_cnt = sh[9] ? 5'(-sh) : 5'(sh);

`ifdef FLOAT_TO_FIXED_ROUND_EN
  logic rnd_q, rnd_d;

  always_comb begin
    rnd_d = rnd_q;
    if (state_q == IDLE && in_valid) begin
      rnd_d = 1'b0;
    end else if (state_q == SHIFT) begin
      rnd_d = left_q ? 1'b0 : mag_q[0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rnd_q <= 1'b0;
    end else begin
      rnd_q <= rnd_d;
    end
  end

  assign mag_fin = mag_q + {31'b0, rnd_q};
`else
  assign mag_fin = mag_q;
`endif

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    count_d     = count_q;
    left_d      = left_q;
    sign_d      = sign_q;
    sat_d       = sat_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = up_sign;
          sat_d   = 1'b0;
          count_d = 5'd0;
          left_d  = 1'b0;
          mag_d   = {8'h00, 1'b1, up_mant};
          state_d = FINISH;
          if (up_zero) begin
            mag_d = '0;
          end else if (up_nan) begin
            mag_d = SAT_POS;
            sat_d = 1'b1;
          end else if (up_inf || sh > 10'sd7) begin
            mag_d = up_sign ? SAT_NEG : SAT_POS;
            sat_d = 1'b1;
          end else if (sh < -10'sd24) begin
            mag_d = '0;
          end else begin
            count_d = sh_cnt;
            left_d  = !sh[9];
            if (sh_cnt != 5'd0) begin
              state_d = SHIFT;
            end
          end
        end
      end
      SHIFT: begin
        mag_d   = left_q ? (mag_q << 1) : (mag_q >> 1);
        count_d = count_q - 5'd1;
        if (count_q == 5'd1) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        // Saturated magnitudes already carry their sign
        result_d    = (sign_q && !sat_q) ? -mag_fin : mag_fin;
        ovf_d       = sat_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      count_q     <= '0;
      left_q      <= 1'b0;
      sign_q      <= 1'b0;
      sat_q       <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      count_q     <= count_d;
      left_q      <= left_d;
      sign_q      <= sign_d;
      sat_q       <= sat_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_float_to_fixed.sv
// Scoreboard bench for float_to_fixed: directed cases plus randomized operands vs a real-arithmetic model.
module tb_float_to_fixed;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] targetnumber = '0;
  logic [4:0]  fixpointpos = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit rand_ready = 1'b0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];

  float_to_fixed dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .targetnumber (targetnumber),
    .fixpointpos  (fixpointpos),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .ovf          (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, want);
    end
  endtask

  // Value-level reference: scale the significand by 2^k in real arithmetic, then range-check
  function automatic void refModel(input logic [31:0] tn, input logic [4:0] fp,
                                   output logic [31:0] er, output logic eo, output int lat);
    int     e;
    int     k;
    real    mag;
    longint v;
    e   = int'(tn[30:23]);
    k   = e - 150 + int'(fp);
    er  = 32'h0;
    eo  = 1'b0;
    lat = 1;
    if (e == 0) return;
    if (e == 255) begin
      eo = 1'b1;
      er = (tn[22:0] != 0) ? 32'h7FFF_FFFF : (tn[31] ? 32'h8000_0000 : 32'h7FFF_FFFF);
      return;
    end
    mag = real'(8388608 + int'(tn[22:0]));
    if (k > 0) for (int i = 0; i < k; i++) mag = mag * 2.0;
    if (k < 0) for (int i = 0; i < -k; i++) mag = mag / 2.0;
    if (mag >= 2147483648.0) begin
      eo = 1'b1;
      er = tn[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      return;
    end
    if (k > 0) lat = 1 + k;
    else if (k >= -24) lat = 1 - k;
`ifdef FLOAT_TO_FIXED_ROUND_EN
    mag = $floor(mag + 0.5);
`else
    mag = $floor(mag);
`endif
    v = longint'(mag);
    if (tn[31]) v = -v;
    er = v[31:0];
  endfunction

  task automatic applyStimulus(input logic [31:0] tn, input logic [4:0] fp, input logic [31:0] er,
                               input logic eo, input int lat, input string name);
    int   waited;
    exp_t x;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL %s/accept_timeout: got in_ready=0, want 1", name);
      return;
    end
    in_valid     = 1'b1;
    targetnumber = tn;
    fixpointpos  = fp;
    @(negedge clk);
    in_valid = 1'b0;
    x.res  = er;
    x.ovf  = eo;
    x.due  = cyc + lat;
    x.name = name;
    sb.push_back(x);
  endtask

  // Random consumer back-pressure, disabled during directed hold checks
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: compare on first presentation, then check the result stays held until consumed
  initial begin
    bit          pending;
    logic [31:0] held_r;
    logic        held_o;
    exp_t        x;
    pending = 1'b0;
    held_r  = '0;
    held_o  = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        pending = 1'b0;
      end else if (out_valid) begin
        if (!pending) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_output: got result=%h with empty scoreboard, want no output", result);
          end else begin
            x = sb.pop_front();
            checkOutput({x.name, "/result"}, result, x.res);
            checkOutput({x.name, "/ovf"}, {31'b0, ovf}, {31'b0, x.ovf});
            checkOutput({x.name, "/latency"}, cyc, x.due);
          end
          held_r  = result;
          held_o  = ovf;
          pending = 1'b1;
        end else begin
          checkOutput("hold/result", result, held_r);
          checkOutput("hold/ovf", {31'b0, ovf}, {31'b0, held_o});
        end
        if (out_ready) pending = 1'b0;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] tn;
    logic [4:0]  fp;
    logic [31:0] er;
    logic        eo;
    int          lat;
    int          sel;
    int          waited;

    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset/in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("reset/out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset/result", result, 32'h0);
    checkOutput("reset/ovf", {31'b0, ovf}, 32'd0);
    rst = 1'b1;
    rand_ready = 1'b1;

    applyStimulus(32'h3F80_0000, 5'd16, 32'h0001_0000, 1'b0, 7 + 1, "one_q16");
    applyStimulus(32'hC049_0FDB, 5'd8,  32'hFFFF_FCDC, 1'b0, 15, "neg_pi_q8");
    applyStimulus(32'h4F00_0000, 5'd0,  32'h7FFF_FFFF, 1'b1, 1, "two31_pos");
    applyStimulus(32'hCF00_0000, 5'd0,  32'h8000_0000, 1'b1, 1, "two31_neg");
`ifdef FLOAT_TO_FIXED_ROUND_EN
    applyStimulus(32'h3F00_0000, 5'd0,  32'h0000_0001, 1'b0, 25, "half_q0");
`else
    applyStimulus(32'h3F00_0000, 5'd0,  32'h0000_0000, 1'b0, 25, "half_q0");
`endif
    applyStimulus(32'h0000_0000, 5'd10, 32'h0000_0000, 1'b0, 1, "zero_q10");
    applyStimulus(32'h7FC0_0000, 5'd10, 32'h7FFF_FFFF, 1'b1, 1, "nan_q10");
    applyStimulus(32'hFF80_0000, 5'd10, 32'h8000_0000, 1'b1, 1, "neg_inf_q10");

    // Hold result in DONE for 5 cycles while ignored in_valid pulses arrive
    @(negedge clk);
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    out_ready = 1'b0;
    applyStimulus(32'h3F80_0000, 5'd16, 32'h0001_0000, 1'b0, 8, "hold_op");
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("hold/out_valid_seen", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid     = 1'b1;
      targetnumber = 32'h4049_0FDB;
      fixpointpos  = 5'd3;
      #3;
      checkOutput("hold/in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("hold/out_valid", {31'b0, out_valid}, 32'd1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rand_ready = 1'b1;

    // Reset in the middle of a 24-step right shift
    applyStimulus(32'h3F00_0000, 5'd0, 32'h0, 1'b0, 25, "reset_victim");
    repeat (5) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    #3;
    checkOutput("rst_mid/in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst_mid/out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_mid/result", result, 32'h0);
    checkOutput("rst_mid/ovf", {31'b0, ovf}, 32'd0);
    applyStimulus(32'hC049_0FDB, 5'd8, 32'hFFFF_FCDC, 1'b0, 15, "after_reset");

    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 19);
      tn[31]    = 1'($urandom_range(0, 1));
      tn[22:0]  = 23'($urandom);
      if (sel == 0)      tn[30:23] = 8'h00;
      else if (sel == 1) tn[30:23] = 8'hFF;
      else               tn[30:23] = 8'($urandom_range(95, 165));
      fp = 5'($urandom_range(0, 31));
      refModel(tn, fp, er, eo, lat);
      applyStimulus(tn, fp, er, eo, lat, $sformatf("rand%0d_%h_q%0d", i, tn, fp));
    end

    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending results, want 0", sb.size());
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
